seg7_display_scheduler: RTL and testbench

Drives the 4-digit seven-segment display of the snake game: scans the four digits in turn, inserts a dead-time blank at each digit change to stop ghosting, and arbitrates the display between the always-present score source and a one-shot message requester. Outputs feed the 7-segment decoder's digit-select, hex-nibble and dot inputs. A separate enable gates the anodes at top level.

---
 rtl/seg7_sched_pkg.sv | 17 +
 rtl/seg7_refresh_timer.sv | 53 +++++
 rtl/seg7_display_scheduler.sv | 132 +++++++++++++
 tb/tb_seg7_display_scheduler.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/seg7_sched_pkg.sv
// Shared types for the seven-segment display scheduler: digit index, arbiter and
// scan states, and the latched per-source display image.
package seg7_sched_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [1:0] digit_t;

    typedef enum logic {SRC_SCORE = 1'b0, SRC_MSG  = 1'b1} src_e;
    typedef enum logic {SCAN_BLANK = 1'b0, SCAN_SHOW = 1'b1} scan_e;

    typedef struct packed {
        logic [NUM_DIGITS-1:0][3:0] nib;
        logic [NUM_DIGITS-1:0]      dots;
    } src_lat_t;

endpackage

// File: rtl/seg7_refresh_timer.sv
// Digit-slot timer: slot counter, digit index, dead-time BLANK/SHOW scan FSM and
// the slot-wrap / frame-boundary strobes (combinational, valid on the wrap edge).
module seg7_refresh_timer
    import seg7_sched_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 200
) (
    input  logic   gclk,
    input  logic   grst_n,
    output digit_t digit_q,
    output digit_t digit_d,
    output logic   show_d,
    output logic   slot_wrap,
    output logic   frame_bound
);

    localparam int               CNT_W      = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] SHOW_FIRST = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    scan_e            scan_q, scan_d;

    assign slot_wrap   = (cnt_q == CNT_LAST);
    assign frame_bound = slot_wrap && (digit_q == digit_t'(NUM_DIGITS - 1));
    assign cnt_d       = slot_wrap ? '0 : cnt_q + 1'b1;
    assign digit_d     = slot_wrap ? digit_q + 2'd1 : digit_q;
    assign show_d      = (scan_d == SCAN_SHOW);

    // State tracks the counter value it will hold, so BLANK is already active on
    // the same edge the digit index moves.
    always_comb begin
        scan_d = scan_q;
        case (scan_q)
            SCAN_BLANK: if (cnt_d >= SHOW_FIRST) scan_d = SCAN_SHOW;
            SCAN_SHOW:  if (cnt_d <  SHOW_FIRST) scan_d = SCAN_BLANK;
        endcase
    end

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            cnt_q   <= '0;
            digit_q <= '0;
            scan_q  <= SCAN_BLANK;
        end else begin
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            scan_q  <= scan_d;
        end
    end

endmodule

// File: rtl/seg7_display_scheduler.sv
// Seven-segment display scheduler: digit scan with dead-time blanking, frame-aligned
// score/message arbitration. Define SEG7_LZ_BLANK_EN to suppress leading zeros of the score.
module seg7_display_scheduler
    import seg7_sched_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 200,
    parameter int HOLD_FRAMES  = 250
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic [15:0] SCORE_IN,
    input  logic [3:0]  SCORE_DOTS_IN,
    input  logic        MSG_REQ_IN,
    input  logic [15:0] MSG_IN,
    input  logic [3:0]  MSG_DOTS_IN,
    output logic        MSG_ACK_OUT,
    output logic [1:0]  SEG_SELECT_OUT,
    output logic [3:0]  BIN_OUT,
    output logic        DOT_OUT,
    output logic        DIGIT_EN_OUT,
    output logic        SOURCE_OUT,
    output logic        FRAME_TICK_OUT
);

    localparam int                HOLD_W    = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

    digit_t            digit_d;
    logic              show_d, slot_wrap, frame_bound;
    src_e              arb_q, arb_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    src_lat_t          score_q, score_d, msg_q, msg_d, shown_d;
    logic              ack_d, lz_d;

    seg7_refresh_timer #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timer (
        .gclk       (CLK),
        .grst_n     (RESETN),
        .digit_q    (SEG_SELECT_OUT),
        .digit_d    (digit_d),
        .show_d     (show_d),
        .slot_wrap  (slot_wrap),
        .frame_bound(frame_bound)
    );

    // Everything changes only at frame boundaries. Leaving SRC_MSG always passes
    // through a full score frame, which is what keeps messages from abutting.
    always_comb begin
        arb_d   = arb_q;
        hold_d  = hold_q;
        score_d = score_q;
        msg_d   = msg_q;
        ack_d   = 1'b0;
        if (frame_bound) begin
            case (arb_q)
                SRC_SCORE: begin
                    if (MSG_REQ_IN) begin
                        arb_d      = SRC_MSG;
                        ack_d      = 1'b1;
                        hold_d     = '0;
                        msg_d.nib  = MSG_IN;
                        msg_d.dots = MSG_DOTS_IN;
                    end else begin
                        score_d.nib  = SCORE_IN;
                        score_d.dots = SCORE_DOTS_IN;
                    end
                end
                SRC_MSG: begin
                    if (hold_q == HOLD_LAST) begin
                        arb_d        = SRC_SCORE;
                        score_d.nib  = SCORE_IN;
                        score_d.dots = SCORE_DOTS_IN;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            arb_q   <= SRC_SCORE;
            hold_q  <= '0;
            score_q <= '0;
            msg_q   <= '0;
        end else begin
            arb_q   <= arb_d;
            hold_q  <= hold_d;
            score_q <= score_d;
            msg_q   <= msg_d;
        end
    end

    assign shown_d = (arb_d == SRC_MSG) ? msg_d : score_d;

`ifdef SEG7_LZ_BLANK_EN
    // A digit is a leading zero when it and every digit to its left are zero and
    // its own dot is off; digit 0 always shows.
    always_comb begin
        lz_d = (arb_d == SRC_SCORE) && (digit_d != '0) && !score_d.dots[digit_d];
        for (int n = 0; n < NUM_DIGITS; n++)
            if (n >= int'(digit_d) && score_d.nib[n] != 4'h0) lz_d = 1'b0;
    end
`else
    assign lz_d = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            BIN_OUT        <= '0;
            DOT_OUT        <= 1'b1;
            DIGIT_EN_OUT   <= 1'b0;
            MSG_ACK_OUT    <= 1'b0;
            FRAME_TICK_OUT <= 1'b0;
        end else begin
            if (slot_wrap) begin
                BIN_OUT <= shown_d.nib[digit_d];
                DOT_OUT <= ~shown_d.dots[digit_d];
            end
            DIGIT_EN_OUT   <= show_d && !lz_d;
            MSG_ACK_OUT    <= ack_d;
            FRAME_TICK_OUT <= frame_bound;
        end
    end

    assign SOURCE_OUT = (arb_q == SRC_MSG);

endmodule

// File: tb/tb_seg7_display_scheduler.sv
// Scoreboard bench for seg7_display_scheduler (REFRESH_DIV=8, BLANK_CYCLES=2, HOLD_FRAMES=2):
// stimulus pushes hand-described per-cycle expectations, a negedge monitor pops and compares.
module tb_seg7_display_scheduler;

    localparam int SLOT  = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 32;

`ifdef SEG7_LZ_BLANK_EN
    localparam logic [3:0] LZ_ZERO = 4'b1110;
    localparam logic [3:0] LZ_0042 = 4'b1100;
`else
    localparam logic [3:0] LZ_ZERO = 4'b0000;
    localparam logic [3:0] LZ_0042 = 4'b0000;
`endif

    logic        CLK = 1'b0;
    logic        RESETN;
    logic [15:0] SCORE_IN, MSG_IN;
    logic [3:0]  SCORE_DOTS_IN, MSG_DOTS_IN;
    logic        MSG_REQ_IN;
    logic        MSG_ACK_OUT, DOT_OUT, DIGIT_EN_OUT, SOURCE_OUT, FRAME_TICK_OUT;
    logic [1:0]  SEG_SELECT_OUT;
    logic [3:0]  BIN_OUT;

    typedef struct {
        logic [1:0] seg;
        logic [3:0] bin;
        logic       dot, en, src, tick, ack;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   sample = 0;

    always #5 CLK = ~CLK;

    seg7_display_scheduler #(
        .REFRESH_DIV (SLOT),
        .BLANK_CYCLES(BLANK),
        .HOLD_FRAMES (2)
    ) dut (
        .CLK           (CLK),
        .RESETN        (RESETN),
        .SCORE_IN      (SCORE_IN),
        .SCORE_DOTS_IN (SCORE_DOTS_IN),
        .MSG_REQ_IN    (MSG_REQ_IN),
        .MSG_IN        (MSG_IN),
        .MSG_DOTS_IN   (MSG_DOTS_IN),
        .MSG_ACK_OUT   (MSG_ACK_OUT),
        .SEG_SELECT_OUT(SEG_SELECT_OUT),
        .BIN_OUT       (BIN_OUT),
        .DOT_OUT       (DOT_OUT),
        .DIGIT_EN_OUT  (DIGIT_EN_OUT),
        .SOURCE_OUT    (SOURCE_OUT),
        .FRAME_TICK_OUT(FRAME_TICK_OUT)
    );

    task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at sample %0d: got %0h, expected %0h", name, sample, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            cmp("seg_select", {2'b00, SEG_SELECT_OUT}, {2'b00, mon_e.seg});
            cmp("bin",        BIN_OUT,                 mon_e.bin);
            cmp("dot",        {3'b000, DOT_OUT},        {3'b000, mon_e.dot});
            cmp("digit_en",   {3'b000, DIGIT_EN_OUT},   {3'b000, mon_e.en});
            cmp("source",     {3'b000, SOURCE_OUT},     {3'b000, mon_e.src});
            cmp("frame_tick", {3'b000, FRAME_TICK_OUT}, {3'b000, mon_e.tick});
            cmp("msg_ack",    {3'b000, MSG_ACK_OUT},    {3'b000, mon_e.ack});
            sample++;
        end
    end

    task automatic push_rst(input int n);
        exp_t e;
        e.seg = 2'd0; e.bin = 4'h0; e.dot = 1'b1; e.en = 1'b0;
        e.src = 1'b0; e.tick = 1'b0; e.ack = 1'b0;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    // First n cycles of a frame showing nib/dots from the given source; mask marks
    // digits expected to stay dark for the whole slot.
    task automatic push_frame(input logic [15:0] nib, input logic [3:0] dots, input logic src,
                              input logic ack, input logic tick, input logic [3:0] mask,
                              input int n);
        exp_t e;
        int   d, c;
        for (int i = 0; i < n; i++) begin
            d      = i / SLOT;
            c      = i % SLOT;
            e.seg  = 2'(d);
            e.bin  = nib[4*d +: 4];
            e.dot  = ~dots[d];
            e.en   = (c >= BLANK) && !mask[d];
            e.src  = src;
            e.tick = tick && (i == 0);
            e.ack  = ack && (i == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESETN        = 1'b0;
        SCORE_IN      = 16'h1234;
        SCORE_DOTS_IN = 4'h0;
        MSG_REQ_IN    = 1'b0;
        MSG_IN        = 16'hDEAD;
        MSG_DOTS_IN   = 4'h0;
        @(posedge CLK); #1;
        push_rst(2); step(2);
        RESETN = 1'b1;

        // latches start cleared, so the first frame shows 0000
        push_frame(16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, LZ_ZERO, FRAME); step(FRAME);
        push_frame(16'h1234, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0, FRAME);
        step(10); SCORE_IN = 16'h5678; step(FRAME - 10);
        push_frame(16'h5678, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0, FRAME);
        step(10); SCORE_DOTS_IN = 4'b0100; step(FRAME - 10);
        push_frame(16'h5678, 4'b0100, 1'b0, 1'b0, 1'b1, 4'h0, FRAME);
        step(10); SCORE_DOTS_IN = 4'h0; MSG_REQ_IN = 1'b1; step(FRAME - 10);

        // message held two frames, one score frame, then re-grant with request still high
        push_frame(16'hDEAD, 4'h0, 1'b1, 1'b1, 1'b1, 4'h0, FRAME); step(FRAME);
        push_frame(16'hDEAD, 4'h0, 1'b1, 1'b0, 1'b1, 4'h0, FRAME); step(FRAME);
        push_frame(16'h5678, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0, FRAME); step(FRAME);
        push_frame(16'hDEAD, 4'h0, 1'b1, 1'b1, 1'b1, 4'h0, FRAME);
        step(10); SCORE_IN = 16'h0042; MSG_REQ_IN = 1'b0; step(FRAME - 10);
        push_frame(16'hDEAD, 4'h0, 1'b1, 1'b0, 1'b1, 4'h0, FRAME);
        step(10); MSG_IN = 16'hBEEF; MSG_DOTS_IN = 4'b0001; step(FRAME - 10);
        push_frame(16'h0042, 4'h0, 1'b0, 1'b0, 1'b1, LZ_0042, FRAME);
        step(10); MSG_REQ_IN = 1'b1; step(FRAME - 10);

        // reset lands mid-message; outputs must drop before the next clock edge
        push_frame(16'hBEEF, 4'b0001, 1'b1, 1'b1, 1'b1, 4'h0, 13); step(13);
        RESETN = 1'b0; MSG_REQ_IN = 1'b0;
        push_rst(2); step(2);
        RESETN = 1'b1;
        push_frame(16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, LZ_ZERO, FRAME); step(FRAME);
        push_frame(16'h0042, 4'h0, 1'b0, 1'b0, 1'b1, LZ_0042, FRAME); step(FRAME);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drained: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
